// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide sequencer.
package mips_muldiv_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'd0,
        OP_DIVU  = 2'd1,
        OP_MULT  = 2'd2,
        OP_DIV   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// acc is the product-high / partial-remainder half, mq the multiplier / dividend-quotient half.
module mips_muldiv_step
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              div_mode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mq,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc_n,
    output logic [DATA_W-1:0] mq_n
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sh;
    logic [DATA_W-1:0] diff;
    logic              ge;

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, (mq[0] ? b : {DATA_W{1'b0}})};
        sh    = {acc, mq[DATA_W-1]};
        ge    = (sh >= {1'b0, b});
        // When sh >= b the difference is below b, so it fits in DATA_W bits.
        diff  = sh[DATA_W-1:0] - b;
        acc_n = sum[DATA_W:1];
        mq_n  = {sum[0], mq[DATA_W-1:1]};
        if (div_mode) begin
            acc_n = ge ? diff : sh[DATA_W-1:0];
            mq_n  = {mq[DATA_W-2:0], ge};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULTU/DIVU sequencer owning HI/LO; one bit per clock, fixed DATA_W+1 cycle latency.
// Define MIPS_MULDIV_SIGNED_EN to enable signed MULT/DIV (op 2/3); otherwise op[1] is ignored.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

`ifdef MIPS_MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic c);
        return c ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg2_if(input logic [2*DATA_W-1:0] v, input logic c);
        return c ? (~v + 1'b1) : v;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, mq_q, b_q, xorig_q;
    logic              neg_q, negrem_q, yzero_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              div0_q;

    logic              ld, iter, last;
    logic              signed_op;
    logic [DATA_W-1:0] xmag, ymag;
    logic [DATA_W-1:0] acc_n, mq_n;
    logic [2*DATA_W-1:0] prod;

    assign signed_op = op[1] & SIGNED_EN;
    assign xmag      = neg_if(X, signed_op & X[DATA_W-1]);
    assign ymag      = neg_if(Y, signed_op & Y[DATA_W-1]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld      = 1'b0;
        iter    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = op[0] ? ST_DIV : ST_MUL;
                    cnt_d   = '0;
                    ld      = 1'b1;
                end
            end
            ST_MUL, ST_DIV: begin
                iter  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    last    = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mips_muldiv_step #(.DATA_W(DATA_W)) u_step (
        .div_mode (state_q == ST_DIV),
        .acc      (acc_q),
        .mq       (mq_q),
        .b        (b_q),
        .acc_n    (acc_n),
        .mq_n     (mq_n)
    );

    // Working registers carry no reset: they are always loaded on the accepting edge.
    always_ff @(posedge clk) begin
        if (ld) begin
            acc_q    <= '0;
            mq_q     <= op[0] ? xmag : ymag;
            b_q      <= op[0] ? ymag : xmag;
            xorig_q  <= X;
            yzero_q  <= (Y == '0);
            neg_q    <= signed_op & (X[DATA_W-1] ^ Y[DATA_W-1]);
            negrem_q <= signed_op & X[DATA_W-1];
        end else if (iter) begin
            acc_q <= acc_n;
            mq_q  <= mq_n;
        end
    end

    assign prod = neg2_if({acc_n, mq_n}, neg_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            div0_q <= 1'b0;
        end else if (last) begin
            if (state_q == ST_MUL) begin
                {hi_q, lo_q} <= prod;
                div0_q       <= 1'b0;
            end else if (yzero_q) begin
                hi_q   <= xorig_q;
                lo_q   <= '1;
                div0_q <= 1'b1;
            end else begin
                hi_q   <= neg_if(acc_n, negrem_q);
                lo_q   <= neg_if(mq_n, neg_q);
                div0_q <= 1'b0;
            end
        end else if (ld) begin
            div0_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            // start is low here (ld covers start in IDLE), so MTHI/MTLO are honoured.
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for MULTU/DIVU, which the single-cycle ALU leaves unimplemented.
- Sits beside the ALU in the execute stage and takes the same X/Y operands.
- Runs an iterative shift-add multiplier or restoring divider, one bit per clock.
- Raises busy so the pipeline stalls any MFHI/MFLO or new mul/div until done.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  0=MULTU, 1=DIVU, 2=MULT, 3=DIV (2/3 need macro)
X  in  DATA_W  multiplicand / dividend
Y  in  DATA_W  multiplier / divisor
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  DATA_W  MTHI/MTLO data
busy  out  1  operation in flight; pipeline stall request
done  out  1  one-cycle pulse; HI/LO hold the new result
div0  out  1  valid with done; divide with Y==0
hi  out  DATA_W  HI register (product high / remainder)
lo  out  DATA_W  LO register (product low / quotient)

Behaviour:
- Reset (async, any state, including mid-operation):
  - State = IDLE; busy=0, done=0, div0=0, hi=0, lo=0, counter=0.
  - Any in-flight result is discarded.
- States and transitions:
  - IDLE: start=1 → MUL (op[0]=0) or DIV (op[0]=1). X, Y and op are latched at the accepting edge and counter is cleared.
  - MUL/DIV: one iteration per edge. After the DATA_W-th iteration → DONE, and hi/lo/div0 are written on that edge.
  - DONE: lasts exactly one cycle, then returns to IDLE. start is not accepted in DONE.
- Timing:
  - start sampled at edge 0 → busy=1 from edge 0 through the DONE cycle inclusive.
  - done=1 for exactly the one cycle following edge DATA_W (the DONE cycle); hi/lo hold the result in that cycle.
  - Latency is 33 cycles at DATA_W=32, fixed and data-independent (no early termination).
- Multiply: {hi,lo} = 64-bit product of the latched X and Y, computed mod 2^(2*DATA_W).
- Divide (restoring): lo = X / Y, hi = X % Y.
  - Y==0: the full latency still elapses; result lo=all-ones, hi=X, div0=1.
- div0 is cleared on the next accepted start. done is never asserted outside DONE.
- start while busy is ignored and not queued.
- MTHI/MTLO (hi_we/lo_we):
  - Honoured only in IDLE with start=0; the register updates at the next edge.
  - Ignored while busy.
  - start and a write in the same IDLE cycle: start wins and the write is dropped.
  - hi_we and lo_we together update both registers with wdata.
- hi/lo are stable at all times except at the result edge and at write edges.

Optional Feature:
MIPS_MULDIV_SIGNED_EN.
- With the macro, op 2/3 (MULT/DIV) run signed:
  - Operands are converted to magnitudes at latch, and the unsigned core runs unchanged.
  - Product is negated when X[31]^Y[31].
  - Quotient is negated when X[31]^Y[31]; remainder takes the sign of X.
  - Y==0 bypasses the sign fix (lo=all-ones, hi=X).
  - MIN_INT/-1 gives lo=0x80000000, hi=0.
- Without the macro, op[1] is ignored and op 2/3 behave as 0/1.

Decomposition:
- Package mips_muldiv_pkg holds:
  - op encodings (OP_MULTU..OP_DIV);
  - state encodings (ST_IDLE, ST_MUL, ST_DIV, ST_DONE);
  - DATA_W default.
- One natural sub-module, mips_muldiv_step: purely combinational single-iteration datapath.
  - Multiply mode: conditional add + shift.
  - Divide mode: trial subtract + shift.
- The FSM, counter, HI/LO registers and sign handling stay in the top.

Test Plan:
- MULTU X=0xFFFFFFFF Y=0xFFFFFFFF → done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001, div0=0; busy high for 33 cycles.
- DIVU X=100 Y=7 → lo=14, hi=2. Then DIVU X=0x12345678 Y=0 → lo=0xFFFFFFFF, hi=0x12345678, div0=1 with done.
- Second start 5 cycles into an operation with different operands → ignored; first result unchanged, single done pulse. hi_we while busy → hi unchanged.
- IDLE: lo_we wdata=0xCAFEBABE → lo=0xCAFEBABE next cycle. start together with hi_we → write dropped, operation runs.
- Reset asserted asynchronously at iteration 10 → busy/done/hi/lo immediately 0. A following MULTU 3×5 gives lo=15, hi=0.
- With MIPS_MULDIV_SIGNED_EN:
  - MULT -3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Without the macro, op=2 with -3×5 → unsigned result hi=0x00000004, lo=0xFFFFFFF1.
